i2s_tx: RTL and testbench

//  I2S transmit end of the codec link: generates MCLK/SCLK/LRCLK from clk and serializes

---
 rtl/i2s_tx.sv | 124 ++++++++++++
 tb/tb_i2s_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// I2S transmitter: divides clk into MCLK/SCLK/LRCLK and serializes left/right
// samples onto SDin, MSB first, with the I2S one-SCLK data delay.
module i2s_tx #(
   parameter int unsigned SMPL_W = 16,
   parameter int unsigned DATA_W = 24
) (
   input  logic              clk,
   input  logic              RST_n,
   input  logic [SMPL_W-1:0] lft_smpl,
   input  logic [SMPL_W-1:0] rht_smpl,
   input  logic              smpl_vld,
   output logic              smpl_rdy,
   output logic              MCLK,
   output logic              SCLK,
   output logic              LRCLK,
   output logic              SDin,
   output logic              frm_strt,
   output logic              underrun
);

   localparam int unsigned CNT_W  = 10;
   localparam int unsigned SLOT_W = 5;
   localparam int unsigned PAD_W  = DATA_W - SMPL_W;
   localparam logic [CNT_W-1:0]  CNT_RST  = 10'h200;
   localparam logic [CNT_W-1:0]  CNT_LOAD = 10'h3FF;
   localparam logic [SLOT_W-1:0] LAST_DATA_SLOT = SLOT_W'(DATA_W);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SMPL_W-1:0] hold_l_q, hold_l_d;
   logic [SMPL_W-1:0] hold_r_q, hold_r_d;
   logic              full_q, full_d;
   logic [DATA_W-1:0] shr_l_q, shr_l_d;
   logic [DATA_W-1:0] shr_r_q, shr_r_d;
   logic              sdin_q, sdin_d;
   logic              frm_strt_q, frm_strt_d;
   logic              underrun_q, underrun_d;

   logic              load;
   logic              accept;
   logic              bit_edge;
   logic [SLOT_W-1:0] slot_nxt;
   logic              half_r_nxt;
   logic              data_slot;

   function automatic logic [DATA_W-1:0] left_just(input logic [SMPL_W-1:0] s);
      return DATA_W'(s) << PAD_W;
   endfunction

   // Decode of the edge about to happen, based on the count it will produce
   always_comb begin
      cnt_d      = cnt_q + 10'd1;
      load       = (cnt_q == CNT_LOAD);
      accept     = smpl_vld & ~full_q;
      bit_edge   = (cnt_q[3:0] == 4'hF);
      slot_nxt   = cnt_d[8:4];
      half_r_nxt = cnt_d[9];
      data_slot  = (slot_nxt != '0) && (slot_nxt <= LAST_DATA_SLOT);
   end

   // Holding register: accepting a new pair wins over the clear caused by a load
   always_comb begin
      hold_l_d = hold_l_q;
      hold_r_d = hold_r_q;
      full_d   = full_q & ~load;
      if (accept) begin
         hold_l_d = lft_smpl;
         hold_r_d = rht_smpl;
         full_d   = 1'b1;
      end
   end

   // Frame load and per-slot shifting; loads always land on a slot-0 edge
   always_comb begin
      shr_l_d    = shr_l_q;
      shr_r_d    = shr_r_q;
      sdin_d     = sdin_q;
      frm_strt_d = load;
      underrun_d = load & ~full_q;
      if (load) begin
         shr_l_d = left_just(hold_l_q);
         shr_r_d = left_just(hold_r_q);
      end else if (bit_edge && data_slot) begin
         if (half_r_nxt) shr_r_d = {shr_r_q[DATA_W-2:0], 1'b0};
         else            shr_l_d = {shr_l_q[DATA_W-2:0], 1'b0};
      end
      if (bit_edge) begin
         if (data_slot) sdin_d = half_r_nxt ? shr_r_q[DATA_W-1] : shr_l_q[DATA_W-1];
         else           sdin_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         cnt_q      <= CNT_RST;
         hold_l_q   <= '0;
         hold_r_q   <= '0;
         full_q     <= 1'b0;
         shr_l_q    <= '0;
         shr_r_q    <= '0;
         sdin_q     <= 1'b0;
         frm_strt_q <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         hold_l_q   <= hold_l_d;
         hold_r_q   <= hold_r_d;
         full_q     <= full_d;
         shr_l_q    <= shr_l_d;
         shr_r_q    <= shr_r_d;
         sdin_q     <= sdin_d;
         frm_strt_q <= frm_strt_d;
         underrun_q <= underrun_d;
      end
   end

   assign MCLK     = cnt_q[1];
   assign SCLK     = cnt_q[3];
   assign LRCLK    = cnt_q[9];
   assign SDin     = sdin_q;
   assign smpl_rdy = ~full_q;
   assign frm_strt = frm_strt_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: a codec-side capture on SCLK rise rebuilds each
// frame and compares it with hand-computed left-justified words.
module tb_i2s_tx;

   logic        clk;
   logic        RST_n;
   logic [15:0] lft_smpl;
   logic [15:0] rht_smpl;
   logic        smpl_vld;
   logic        smpl_rdy;
   logic        MCLK;
   logic        SCLK;
   logic        LRCLK;
   logic        SDin;
   logic        frm_strt;
   logic        underrun;

   i2s_tx #(.SMPL_W(16), .DATA_W(24)) dut (
      .clk      (clk),
      .RST_n    (RST_n),
      .lft_smpl (lft_smpl),
      .rht_smpl (rht_smpl),
      .smpl_vld (smpl_vld),
      .smpl_rdy (smpl_rdy),
      .MCLK     (MCLK),
      .SCLK     (SCLK),
      .LRCLK    (LRCLK),
      .SDin     (SDin),
      .frm_strt (frm_strt),
      .underrun (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Cycles since reset release; (512 + cyc) mod 1024 is the expected counter
   int unsigned cyc;
   always @(posedge clk or negedge RST_n)
      if (!RST_n) cyc <= 0;
      else        cyc <= cyc + 1;

   logic [9:0]  mcnt;
   int unsigned tb_bad = 0;
   int unsigned n_frm  = 0;
   int unsigned n_und  = 0;
   always @(negedge clk) begin
      mcnt = 10'(512 + cyc);
      if ({MCLK, SCLK, LRCLK} !== {mcnt[1], mcnt[3], mcnt[9]}) tb_bad++;
      if (frm_strt === 1'b1) n_frm++;
      if (underrun === 1'b1) n_und++;
   end

   // Codec model: samples SDin on SCLK rise, slot 0 follows each LRCLK change
   logic [47:0] cap_q[$];
   logic [23:0] word;
   logic [23:0] cap_l;
   logic        have_l = 1'b0;
   logic        sync   = 1'b0;
   logic        lr_last;
   int          slot;
   int unsigned pad_bad = 0;
   always @(posedge SCLK or negedge RST_n) begin
      if (!RST_n) begin
         sync   = 1'b0;
         have_l = 1'b0;
      end else begin
         if (!sync || LRCLK !== lr_last) begin
            slot    = 0;
            lr_last = LRCLK;
            sync    = 1'b1;
            word    = '0;
         end else begin
            slot++;
         end
         if (slot == 0 || slot > 24) begin
            if (SDin !== 1'b0) pad_bad++;
         end else begin
            word = {word[22:0], SDin};
            if (slot == 24) begin
               if (!LRCLK) begin
                  cap_l  = word;
                  have_l = 1'b1;
               end else if (have_l) begin
                  cap_q.push_back({cap_l, word});
                  have_l = 1'b0;
               end
            end
         end
      end
   end

   // Called at a negedge; holds the pair until the handshake completes
   task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
      logic was_rdy;
      int   g;
      lft_smpl = l;
      rht_smpl = r;
      smpl_vld = 1'b1;
      g = 0;
      do begin
         was_rdy = smpl_rdy;
         @(negedge clk);
         g++;
      end while (!was_rdy && g < 3000);
      chk("send_accepted", was_rdy, 1'b1);
      smpl_vld = 1'b0;
   endtask

   task automatic wait_frames(input string tag, input int n);
      int g;
      g = 0;
      while (cap_q.size() < n && g < 4000 * n) begin
         @(negedge clk);
         g++;
      end
      chk(tag, (cap_q.size() >= n), 1'b1);
   endtask

   task automatic wait_cnt(input logic [9:0] v);
      int g;
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (10'(512 + cyc) != v && g < 2100);
      chk("wait_cnt_reached", 10'(512 + cyc), v);
   endtask

   int unsigned frm0, und0, viol, rdy_hi, frm_seen, k, g;
   logic [15:0] exp_l[$];
   logic [15:0] exp_r[$];
   logic [15:0] dl;

   initial begin
      RST_n    = 1'b0;
      lft_smpl = '0;
      rht_smpl = '0;
      smpl_vld = 1'b0;

      // Reset values
      #12;
      chk("rst_mclk",  MCLK, 1'b0);
      chk("rst_sclk",  SCLK, 1'b0);
      chk("rst_lrclk", LRCLK, 1'b1);
      chk("rst_sdin",  SDin, 1'b0);
      chk("rst_rdy",   smpl_rdy, 1'b1);
      chk("rst_frm",   frm_strt, 1'b0);
      chk("rst_und",   underrun, 1'b0);
      @(negedge clk);
      RST_n = 1'b1;

      // Pair before the first frame: 8001/7FFE
      send_pair(16'h8001, 16'h7FFE);
      chk("rdy_low_after_accept", smpl_rdy, 1'b0);
      g = 0;
      while (LRCLK !== 1'b0 && g < 2000) begin
         @(negedge clk);
         g++;
      end
      chk("first_lrclk_fall_cyc", cyc, 512);
      wait_frames("frame1_arrived", 1);
      chk("frame1_data", cap_q[0], {24'h800100, 24'h7FFE00});
      chk("frame1_frm_cnt", n_frm, 1);
      chk("frame1_und_cnt", n_und, 0);
      cap_q.delete();

      // One pair then three starved frames: same pair repeats
      frm0 = n_frm;
      und0 = n_und;
      send_pair(16'h1234, 16'hABCD);
      wait_frames("repeat_arrived", 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("repeat_frame%0d", i), cap_q[i], {24'h123400, 24'hABCD00});
      chk("repeat_und_pulses", n_und - und0, 3);
      chk("repeat_frm_pulses", n_frm - frm0, 4);
      cap_q.delete();

      // Continuous valid with a new pair each cycle
      und0 = n_und;
      viol = 0; rdy_hi = 0; frm_seen = 0; k = 0; g = 0;
      while (cap_q.size() < 3 && g < 5000) begin
         if (frm_strt === 1'b1) frm_seen++;
         if (smpl_rdy === 1'b1) rdy_hi++;
         if (k > 0 && smpl_rdy !== frm_strt) viol++;
         dl = 16'(k * 32'h1111 + 3);
         lft_smpl = dl;
         rht_smpl = ~dl;
         smpl_vld = 1'b1;
         if (smpl_rdy === 1'b1) begin
            exp_l.push_back(dl);
            exp_r.push_back(~dl);
         end
         k++;
         g++;
         @(negedge clk);
      end
      smpl_vld = 1'b0;
      chk("stream_arrived", (cap_q.size() >= 3), 1'b1);
      chk("stream_rdy_vs_load", viol, 0);
      chk("stream_rdy_cycles", rdy_hi, frm_seen + 1);
      chk("stream_und", n_und - und0, 0);
      for (int i = 0; i < 3; i++)
         chk($sformatf("stream_frame%0d", i), cap_q[i],
             {exp_l[i], 8'h00, exp_r[i], 8'h00});

      // Valid arriving on the load edge while full
      wait_cnt(10'h100);
      send_pair(16'h0F0F, 16'hF0F0);
      wait_cnt(10'h3FF);
      cap_q.delete();
      und0 = n_und;
      chk("edge_rdy_low", smpl_rdy, 1'b0);
      send_pair(16'h5A5A, 16'hA5A5);
      wait_frames("edge_arrived", 2);
      chk("edge_old_pair", cap_q[0], {24'h0F0F00, 24'hF0F000});
      chk("edge_new_pair", cap_q[1], {24'h5A5A00, 24'hA5A500});
      chk("edge_und", n_und - und0, 0);

      // Asynchronous reset in the middle of the right half
      wait_cnt(10'h280);
      #3;
      RST_n = 1'b0;
      #1;
      chk("mid_rst_mclk",  MCLK, 1'b0);
      chk("mid_rst_sclk",  SCLK, 1'b0);
      chk("mid_rst_lrclk", LRCLK, 1'b1);
      chk("mid_rst_sdin",  SDin, 1'b0);
      chk("mid_rst_rdy",   smpl_rdy, 1'b1);
      chk("mid_rst_und",   underrun, 1'b0);
      @(negedge clk);
      @(negedge clk);
      RST_n = 1'b1;
      cap_q.delete();
      und0 = n_und;
      send_pair(16'hC3C3, 16'h3C3C);
      g = 0;
      while (frm_strt !== 1'b1 && g < 2000) begin
         @(negedge clk);
         g++;
      end
      chk("post_rst_load_cyc", cyc, 512);
      wait_frames("post_rst_arrived", 1);
      chk("post_rst_frame", cap_q[0], {24'hC3C300, 24'h3C3C00});
      chk("post_rst_und", n_und - und0, 0);

      chk("pad_slots_zero", pad_bad, 0);
      chk("timebase_errors", tb_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
